// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner:
// digit count, blank glyph, digit-index type and the hex glyph table.
package display_pkg;

   localparam int DIGITS_C = 8;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef logic [$clog2(DIGITS_C)-1:0] digit_idx_t;

   // Active-low {g,f,e,d,c,b,a} glyphs, entry n is the glyph for nibble n
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      return HEX_SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Look up the glyph for the current nibble
   always_comb begin
      seg = hex_glyph(nibble);
   end

endmodule

// File: rtl/display_scan.sv
// Eight-digit common-anode seven-segment scanner with a frame-synchronous
// shadow register (tear-free) and a sticky halt indicator on the digit-0 dp.
// Optional build macro DISPLAY_SCAN_HALT_BLINK_EN: while halted, the panel
// alternates BLINK_FRAMES visible frames with BLINK_FRAMES blanked frames.
module display_scan
   import display_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int DIGITS       = 8
`ifdef DISPLAY_SCAN_HALT_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 2
`endif
)(
   input  logic        in_CLK,
   input  logic        in_RST_N,
   input  logic [31:0] in_display,
   input  logic        in_lock,
   output logic [7:0]  out_an,
   output logic [6:0]  out_seg,
   output logic        out_dp,
   output logic        out_halted
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam digit_idx_t LAST_DIGIT = digit_idx_t'(DIGITS - 1);

   logic [PRE_W-1:0] prescaler_r;
   digit_idx_t       digit_idx_r;
   logic [31:0]      shadow_r;
   logic             halted_r;
   logic [7:0]       an_r;
   logic [6:0]       seg_r;
   logic             dp_r;

   logic             tick_s;
   logic             wrap_s;
   logic             halted_s;
   logic             blank_s;
   logic [3:0]       nibble_s;
   logic [6:0]       glyph_s;
   logic [7:0]       an_s;
   logic [6:0]       seg_s;
   logic             dp_s;

   // Scan tick, frame wrap and halt look-ahead (lock sampled this edge counts)
   always_comb begin
      tick_s   = (prescaler_r == PRE_W'(CLK_DIV - 1));
      wrap_s   = tick_s && (digit_idx_r == LAST_DIGIT);
      halted_s = halted_r | in_lock;
      nibble_s = shadow_r[{digit_idx_r, 2'b00} +: 4];
   end

   // Prescaler, digit index, frame-synchronous shadow capture, sticky halt
   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         prescaler_r <= '0;
         digit_idx_r <= '0;
         shadow_r    <= 32'h0000_0000;
         halted_r    <= 1'b0;
      end else begin
         halted_r <= halted_s;
         if (tick_s) begin
            prescaler_r <= '0;
            if (wrap_s) begin
               digit_idx_r <= '0;
               shadow_r    <= in_display;
            end else begin
               digit_idx_r <= digit_idx_r + digit_idx_t'(1);
            end
         end else begin
            prescaler_r <= prescaler_r + PRE_W'(1);
         end
      end
   end

`ifdef DISPLAY_SCAN_HALT_BLINK_EN
   localparam int FRAME_W = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;

   logic [FRAME_W-1:0] frame_cnt_r;

   // Frame counter, modulo one full blink period
   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         frame_cnt_r <= '0;
      end else if (wrap_s) begin
         if (frame_cnt_r == FRAME_W'(2 * BLINK_FRAMES - 1)) begin
            frame_cnt_r <= '0;
         end else begin
            frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
         end
      end
   end

   // Second half of each blink period is blanked, only while halted
   always_comb begin
      blank_s = halted_s && (frame_cnt_r >= FRAME_W'(BLINK_FRAMES));
   end
`else
   // Panel is always visible in this build
   always_comb begin
      blank_s = 1'b0;
   end
`endif

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble_s),
      .seg    (glyph_s)
   );

   // Next pin values: one-hot-low anode, glyph and halt dp, or blank
   always_comb begin
      an_s  = 8'hFF;
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
      if (!blank_s) begin
         an_s  = ~(8'h01 << digit_idx_r);
         seg_s = glyph_s;
         dp_s  = ~(halted_s && (digit_idx_r == digit_idx_t'(0)));
      end else begin
         an_s  = 8'hFF;
         seg_s = SEG_BLANK;
         dp_s  = 1'b1;
      end
   end

   // Registered pin drivers
   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         an_r  <= 8'hFF;
         seg_r <= SEG_BLANK;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= an_s;
         seg_r <= seg_s;
         dp_r  <= dp_s;
      end
   end

   assign out_an     = an_r;
   assign out_seg    = seg_r;
   assign out_dp     = dp_r;
   assign out_halted = halted_r;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (CLK_DIV=4, 8 digits, 32-cycle frame).
module tb_display_scan;

   logic        in_CLK = 1'b0;
   logic        in_RST_N = 1'b0;
   logic [31:0] in_display = 32'h0;
   logic        in_lock = 1'b0;
   logic [7:0]  out_an;
   logic [6:0]  out_seg;
   logic        out_dp;
   logic        out_halted;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct packed {
      logic [3:0] key;
      logic [7:0] an;
      logic [6:0] seg;
   } vec_t;

   vec_t scan_tbl [8];
   vec_t dec_tbl  [16];

   display_scan #(.CLK_DIV(4), .DIGITS(8)) dut (
      .in_CLK     (in_CLK),
      .in_RST_N   (in_RST_N),
      .in_display (in_display),
      .in_lock    (in_lock),
      .out_an     (out_an),
      .out_seg    (out_seg),
      .out_dp     (out_dp),
      .out_halted (out_halted)
   );

   always #5 in_CLK = ~in_CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge in_CLK);
      #1;
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_an"},     {24'h0, out_an},     32'hFF);
      chk({tag, "_seg"},    {25'h0, out_seg},    32'h7F);
      chk({tag, "_dp"},     {31'h0, out_dp},     32'h1);
      chk({tag, "_halted"}, {31'h0, out_halted}, 32'h0);
   endtask

   // Frame index since reset (frames start at cycles 0,32,64...) decides blink phase
   function automatic logic blanked(input int base, input logic h);
`ifdef DISPLAY_SCAN_HALT_BLINK_EN
      return h && (((base / 32) % 4) >= 2);
`else
      return h & 1'b0 & (base < 0);
`endif
   endfunction

   // Runs one frame starting at a frame boundary and checks every cycle
   task automatic check_frame(input logic [31:0] val, input logic h);
      int base;
      int d;
      logic [7:0] exp_an;
      logic [3:0] nib;
      base = cyc;
      for (int c = 0; c < 32; c++) begin
         tick();
         d = c / 4;
         if (blanked(base, h)) begin
            chk("frame_blank_an",  {24'h0, out_an},  32'hFF);
            chk("frame_blank_seg", {25'h0, out_seg}, 32'h7F);
            chk("frame_blank_dp",  {31'h0, out_dp},  32'h1);
         end else begin
            exp_an = 8'hFF ^ (8'h01 << d);
            nib    = val[4*d +: 4];
            chk("frame_an",  {24'h0, out_an},  {24'h0, exp_an});
            chk("frame_seg", {25'h0, out_seg}, {25'h0, dec_tbl[nib].seg});
            chk("frame_dp",  {31'h0, out_dp},  (h && d == 0) ? 32'h0 : 32'h1);
         end
         chk("frame_halted", {31'h0, out_halted}, {31'h0, h});
      end
   endtask

   initial begin
      int d;
      // 0123ABCD: digit 0 rightmost
      scan_tbl[0] = '{4'd0, 8'hFE, 7'h21};
      scan_tbl[1] = '{4'd1, 8'hFD, 7'h46};
      scan_tbl[2] = '{4'd2, 8'hFB, 7'h03};
      scan_tbl[3] = '{4'd3, 8'hF7, 7'h08};
      scan_tbl[4] = '{4'd4, 8'hEF, 7'h30};
      scan_tbl[5] = '{4'd5, 8'hDF, 7'h24};
      scan_tbl[6] = '{4'd6, 8'hBF, 7'h79};
      scan_tbl[7] = '{4'd7, 8'h7F, 7'h40};
      dec_tbl[0]  = '{4'h0, 8'hFE, 7'h40};
      dec_tbl[1]  = '{4'h1, 8'hFE, 7'h79};
      dec_tbl[2]  = '{4'h2, 8'hFE, 7'h24};
      dec_tbl[3]  = '{4'h3, 8'hFE, 7'h30};
      dec_tbl[4]  = '{4'h4, 8'hFE, 7'h19};
      dec_tbl[5]  = '{4'h5, 8'hFE, 7'h12};
      dec_tbl[6]  = '{4'h6, 8'hFE, 7'h02};
      dec_tbl[7]  = '{4'h7, 8'hFE, 7'h78};
      dec_tbl[8]  = '{4'h8, 8'hFE, 7'h00};
      dec_tbl[9]  = '{4'h9, 8'hFE, 7'h10};
      dec_tbl[10] = '{4'hA, 8'hFE, 7'h08};
      dec_tbl[11] = '{4'hB, 8'hFE, 7'h03};
      dec_tbl[12] = '{4'hC, 8'hFE, 7'h46};
      dec_tbl[13] = '{4'hD, 8'hFE, 7'h21};
      dec_tbl[14] = '{4'hE, 8'hFE, 7'h06};
      dec_tbl[15] = '{4'hF, 8'hFE, 7'h0E};

      // Reset held from time zero
      #12;
      chk_reset_vals("reset");
      @(posedge in_CLK);
      #1;
      in_RST_N   = 1'b1;
      in_display = 32'h0123ABCD;
      cyc        = 0;

      // Frame 1: shadow still zero, first edge gives FE/40, 4 cycles per digit
      check_frame(32'h0, 1'b0);

      // Frame 2: captured value, table-driven
      for (int c = 0; c < 32; c++) begin
         tick();
         d = c / 4;
         chk("scan_an",  {24'h0, out_an},  {24'h0, scan_tbl[d].an});
         chk("scan_seg", {25'h0, out_seg}, {25'h0, scan_tbl[d].seg});
      end

      // Frame 3: in_display changes while digit 3 is lit, frame must not tear
      for (int c = 0; c < 32; c++) begin
         tick();
         d = c / 4;
         chk("tear_an",  {24'h0, out_an},  {24'h0, scan_tbl[d].an});
         chk("tear_seg", {25'h0, out_seg}, {25'h0, scan_tbl[d].seg});
         if (c == 12) in_display = 32'hFFFFFFFF;
      end
      // Frame 4: new value everywhere
      check_frame(32'hFFFFFFFF, 1'b0);

      // Decoder sweep on digit 0
      for (int i = 0; i < 16; i++) begin
         in_display = {28'h0, dec_tbl[i].key};
         ticks(32);
         tick();
         chk("dec_an",  {24'h0, out_an},  {24'h0, dec_tbl[i].an});
         chk("dec_seg", {25'h0, out_seg}, {25'h0, dec_tbl[i].seg});
         ticks(31);
      end

      // Halt: one-cycle lock pulse mid-frame, flag is sticky
      ticks(5);
      chk("pre_halt", {31'h0, out_halted}, 32'h0);
      in_lock = 1'b1;
      tick();
      in_lock = 1'b0;
      chk("halt_set",    {31'h0, out_halted}, 32'h1);
      chk("halt_dp_d1",  {31'h0, out_dp},     32'h1);
      ticks(26);
      chk("halt_sticky", {31'h0, out_halted}, 32'h1);
      check_frame(32'h0000000F, 1'b1);
      check_frame(32'h0000000F, 1'b1);
      check_frame(32'h0000000F, 1'b1);
      check_frame(32'h0000000F, 1'b1);

      // Asynchronous reset mid-scan, then restart at digit 0 with halt cleared
      ticks(10);
      in_RST_N = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      ticks(2);
      chk_reset_vals("rst_hold");
      in_RST_N = 1'b1;
      cyc      = 0;
      check_frame(32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Consumes the 32-bit display word and the halt (lock) flag from the syscall stage.
- Drives an 8-digit, common-anode, multiplexed seven-segment panel with the word as hex.
- Sits directly downstream of the syscall/display register, at the top-level board I/O.
- Frame-synchronous shadow capture guarantees a tear-free display. A sticky halt indicator lights when the CPU locks.

Parameters:
- CLK_DIV, 4, clock cycles each digit stays enabled (≥2).
- DIGITS, 8, number of hex digits scanned (fixed 8 for a 32-bit word; other values unsupported).
- BLINK_FRAMES, 2, frames on and frames off per blink half-period (used only with the optional feature).

Ports:
- in_CLK  input  1  system clock, all state on rising edge.
- in_RST_N  input  1  asynchronous active-low reset.
- in_display  input  32  value to show; digit k shows in_display[4k+3:4k], digit 0 rightmost.
- in_lock  input  1  halt flag from the syscall stage, level, sampled each cycle.
- out_an  output  8  digit enables, active-low, one-hot-low while scanning.
- out_seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- out_dp  output  1  decimal point, active-low.
- out_halted  output  1  sticky halt status, active-high.

Behaviour:
- Reset (async, in_RST_N=0), effective immediately, no clock needed:
  - out_an=8'hFF, out_seg=7'h7F, out_dp=1, out_halted=0.
  - Prescaler=0, digit index=0, shadow=0, frame counter=0.
- Prescaler counts 0..CLK_DIV-1 and wraps.
  - Terminal count (prescaler==CLK_DIV-1) is a "tick".
  - On a tick the digit index increments mod DIGITS.
- Frame wrap is a tick with index==DIGITS-1. On frame wrap:
  - Shadow <= in_display, in the same edge the index returns to 0.
  - The frame counter increments.
  - in_display changes mid-frame never appear until the next frame.
- Outputs are registered (1-cycle latency from index/shadow to pins).
  - The first rising edge after reset release drives out_an=8'hFE with the digit-0 glyph of shadow (0 → "0", seg 7'h40).
  - Each digit is enabled for exactly CLK_DIV consecutive cycles.
  - Never zero digits and never more than one digit enabled at a time, except when blanked by the optional feature.
- Decode (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Halt:
  - The halted flag is set on any rising edge with in_lock=1 and cleared only by reset.
  - out_halted reflects the flag 1 cycle after in_lock is sampled.
  - While halted, out_dp=0 when digit 0 is enabled, 1 otherwise.
  - in_lock dropping later does not clear the flag.
  - Shadow capture continues while halted, so the final value stays displayed.
- Simultaneous events:
  - A frame wrap coinciding with an in_display change captures the new value.
  - in_lock asserted on a frame-wrap edge sets halted in the same edge.
- Reset mid-scan forces the reset values asynchronously; scanning restarts at digit 0.

Optional Feature:
- Macro: DISPLAY_SCAN_HALT_BLINK_EN.
- Defined:
  - When halted, the panel alternates BLINK_FRAMES frames visible, then BLINK_FRAMES frames blanked.
  - Blanked means out_an=8'hFF, seg/dp=1.
  - The frame counter is mod 2*BLINK_FRAMES; scanning timing is unchanged.
  - Not halted means never blanked.
- Undefined: no frame-counter blink logic; the panel is always visible.

Decomposition:
- Shared package display_pkg holds:
  - DIGITS_C=8 and SEG_BLANK=7'h7F.
  - The 16-entry hex-to-segment constant table.
  - The digit-index typedef (3 bits).
- One sub-module, hex_to_seg7: purely combinational 4-bit to 7-bit decoder using the package table. It is instantiated once on the muxed nibble.

Test Plan:
- Reset sequencing: hold in_RST_N=0 mid-scan → outputs FF/7F/1/0 asynchronously. Release → out_an=FE, seg=40 after 1 edge, with each digit held 4 cycles.
- Full scan: in_display=32'h0123ABCD, wait one frame.
  - Next frame digits 0..7 show d,C,b,A,3,2,1,0 (21,46,03,08,30,24,79,40).
  - out_an steps FE,FD,FB,...,7F, with a 32-cycle frame.
- Tear-free: change in_display to 32'hFFFFFFFF while digit 3 is enabled → digits 4..7 still show the old value this frame; all show F (0E) from the next frame.
- Halt: pulse in_lock=1 for one cycle → out_halted=1 the next cycle and stays 1. out_dp=0 only while out_an=FE; displayed value is unchanged.
- Blink (macro defined, BLINK_FRAMES=2): after halt, frames alternate 2 visible / 2 with out_an=FF. Without the macro, out_an is never FF after reset release.
- Decoder: sweep all 16 nibbles on digit 0 → seg matches the table exactly.
